elevator_scan_ctrl: RTL



---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elev_tick_timer.sv | 28 ++
 rtl/elevator_scan_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared state encoding, default timing constants and floor decode for the elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MOVE = 2'b01,
        DOOR = 2'b10
    } elev_state_t;

    localparam int DEF_TICKS_PER_FLOOR = 250_000_000;
    localparam int DEF_DOOR_TICKS      = 100_000_000;
    localparam int MAX_FLOORS          = 16;
    localparam int MAX_FLOOR_W         = 4;

    function automatic logic [MAX_FLOORS-1:0] floor_onehot(input logic [MAX_FLOOR_W-1:0] idx);
        floor_onehot      = '0;
        floor_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Restartable tick counter running 0..TERMINAL-1; done flags the terminal cycle.
// start and hold both park the count at zero; hold is the level-style form.
module elev_tick_timer #(
    parameter int TERMINAL = 4,
    localparam int CNT_W   = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic done
);

    logic [CNT_W-1:0] count;
    logic             at_tc;

    assign at_tc = (count == CNT_W'(TERMINAL - 1));
    assign done  = at_tc && !start && !hold;

    always_ff @(posedge clk) begin
        if (rst || start || hold || at_tc) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: latches floor requests and sweeps up/down serving them.
// Optional ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open while high.
//
// state | meaning
// IDLE  | parked with doors closed, nothing pending
// MOVE  | travelling one floor per TICKS_PER_FLOOR cycles
// DOOR  | doors open for DOOR_TICKS cycles at the current floor
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS        = 8,
    parameter int TICKS_PER_FLOOR = DEF_TICKS_PER_FLOOR,
    parameter int DOOR_TICKS      = DEF_DOOR_TICKS,
    localparam int FLOOR_W        = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] req,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                door_hold,
`endif
    output logic [FLOOR_W-1:0]  floor,
    output logic [N_FLOORS-1:0] floor_led,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic                arrive
);

    elev_state_t         state, state_nxt;
    logic [N_FLOORS-1:0] above_mask, below_mask, pending_nxt;
    logic [FLOOR_W-1:0]  next_floor, door_floor;
    logic                pend_up, pend_dn, ahead, behind;
    logic                req_here, serve_here, at_limit, stop_here, turn;
    logic                travel_start, travel_done, door_start, door_done, door_hold_i;

`ifdef ELEV_DOOR_HOLD_EN
    assign door_hold_i = door_hold;
`else
    assign door_hold_i = 1'b0;
`endif

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
        end
    end

    assign pend_up    = |(pending & above_mask);
    assign pend_dn    = |(pending & below_mask);
    assign ahead      = dir_up ? pend_up : pend_dn;
    assign behind     = dir_up ? pend_dn : pend_up;
    assign req_here   = req[floor];
    assign serve_here = pending[floor] | req_here;

    // The clamp only guards against illegal operation; a pending target always lies ahead.
    assign at_limit   = dir_up ? (floor == FLOOR_W'(N_FLOORS - 1)) : (floor == '0);
    assign next_floor = at_limit ? floor
                      : (dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1));
    assign stop_here  = pending[next_floor];

    assign travel_start = (state != MOVE);
    assign door_start   = (state != DOOR) || req_here;

    elev_tick_timer #(.TERMINAL(TICKS_PER_FLOOR)) u_travel_timer (
        .clk   (clk),
        .rst   (rst),
        .start (travel_start),
        .hold  (1'b0),
        .done  (travel_done)
    );

    elev_tick_timer #(.TERMINAL(DOOR_TICKS)) u_door_timer (
        .clk   (clk),
        .rst   (rst),
        .start (door_start),
        .hold  (door_hold_i),
        .done  (door_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (serve_here) begin
                    state_nxt = DOOR;
                end else if (ahead || behind) begin
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (travel_done && stop_here) begin
                    state_nxt = DOOR;
                end
            end
            DOOR: begin
                if (door_done) begin
                    state_nxt = (ahead || behind) ? MOVE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        moving    = (state == MOVE);
        door_open = (state == DOOR);
    end

    // Reverse only when the current sweep has nothing left and the other side does.
    assign turn = !ahead && behind &&
                  (((state == IDLE) && !serve_here) || ((state == DOOR) && door_done));

    assign door_floor = (state == MOVE) ? next_floor : floor;

    always_comb begin
        pending_nxt = pending | req;
        if (state_nxt == DOOR) begin
            pending_nxt[door_floor] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            floor     <= '0;
            floor_led <= N_FLOORS'(1);
            pending   <= '0;
            dir_up    <= 1'b1;
            arrive    <= 1'b0;
        end else begin
            floor_led <= N_FLOORS'(floor_onehot(MAX_FLOOR_W'(floor)));
            pending   <= pending_nxt;
            arrive    <= (state_nxt == DOOR) && (state != DOOR);
            if ((state == MOVE) && travel_done) begin
                floor <= next_floor;
            end
            if (turn) begin
                dir_up <= ~dir_up;
            end
        end
    end

    a_no_clamp : assert property (@(posedge clk) disable iff (rst)
        ((state == MOVE) && travel_done) |-> !at_limit);

endmodule
